// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-port AXI4 read arbiter.
// The optional stall watchdog is enabled in the top with AXI_RD_ARB_TIMEOUT_EN.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IFETCH = 1'b0;
    localparam req_id_t REQ_LOAD   = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: bit 0 is the fetch port, bit 1 the load port.
// On a tie, the port that did not win last time gets the grant.
module rr_arbiter2
    import axi_rd_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last,
    output logic [1:0] o_grant_onehot
);

    always_comb begin
        o_grant_onehot = 2'b00;
        case (i_req)
            2'b01:   o_grant_onehot = 2'b01;
            2'b10:   o_grant_onehot = 2'b10;
            2'b11:   o_grant_onehot = (i_last == REQ_LOAD) ? 2'b01 : 2'b10;
            default: o_grant_onehot = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between the fetch (I) and load (D) ports, one burst at a time.
// Optional stall watchdog: define AXI_RD_ARB_TIMEOUT_EN; otherwise TIMEOUT is tied low.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] DRAM_BASE,

    input  logic              I_ARVALID,
    output logic              I_ARREADY,
    input  logic [ADDR_W-1:0] I_ARADDR,
    input  logic [7:0]        I_ARLEN,
    output logic              I_RVALID,
    input  logic              I_RREADY,
    output logic [DATA_W-1:0] I_RDATA,
    output logic [1:0]        I_RRESP,
    output logic              I_RLAST,

    input  logic              D_ARVALID,
    output logic              D_ARREADY,
    input  logic [ADDR_W-1:0] D_ARADDR,
    input  logic [7:0]        D_ARLEN,
    output logic              D_RVALID,
    input  logic              D_RREADY,
    output logic [DATA_W-1:0] D_RDATA,
    output logic [1:0]        D_RRESP,
    output logic              D_RLAST,

    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    output logic [ADDR_W-1:0] M_ARADDR,
    output logic [7:0]        M_ARLEN,
    output logic              M_ARID,
    input  logic              M_RVALID,
    output logic              M_RREADY,
    input  logic [DATA_W-1:0] M_RDATA,
    input  logic [1:0]        M_RRESP,
    input  logic              M_RLAST,
    input  logic              M_RID,

    output logic              BUSY,
    output logic              OWNER,
    output logic              TIMEOUT
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeoutCycles
        $error("TIMEOUT_CYCLES must fit the 16-bit stall counter");
    end

    state_t            r_state;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    req_id_t           r_arid;
    req_id_t           r_lastGrant;
    req_id_t           r_owner;

    logic              w_isIdle;
    logic              w_inAddr;
    logic              w_inData;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_accept;
    req_id_t           w_grantId;
    logic [ADDR_W-1:0] w_grantAddr;
    logic [7:0]        w_grantLen;
    logic              w_arHandshake;
    logic              w_rHandshake;
    logic              w_ownerRready;
    logic              w_selI;
    logic              w_selD;

    assign w_isIdle = (r_state == IDLE);
    assign w_inAddr = (r_state == ADDR);
    assign w_inData = (r_state == DATA);

    // Requests are only visible to the arbiter in IDLE, so nobody is accepted mid-burst.
    assign w_req = w_isIdle ? {D_ARVALID, I_ARVALID} : 2'b00;

    rr_arbiter2 u_rrArbiter (
        .i_req          (w_req),
        .i_last         (r_lastGrant),
        .o_grant_onehot (w_grant)
    );

    assign w_accept    = |w_grant;
    assign w_grantId   = w_grant[1] ? REQ_LOAD : REQ_IFETCH;
    assign w_grantAddr = (w_grantId == REQ_LOAD) ? D_ARADDR : I_ARADDR;
    assign w_grantLen  = (w_grantId == REQ_LOAD) ? D_ARLEN  : I_ARLEN;

    assign I_ARREADY = w_grant[0];
    assign D_ARREADY = w_grant[1];

    assign w_arHandshake = w_inAddr & M_ARREADY;
    assign w_ownerRready = (r_owner == REQ_LOAD) ? D_RREADY : I_RREADY;
    assign w_rHandshake  = w_inData & M_RVALID & w_ownerRready;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arid      <= REQ_IFETCH;
            r_lastGrant <= REQ_LOAD;
            r_owner     <= REQ_IFETCH;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // The base is sampled at the grant; a carry out of the sum is dropped.
                        r_araddr    <= DRAM_BASE + w_grantAddr;
                        r_arlen     <= w_grantLen;
                        r_arid      <= w_grantId;
                        r_lastGrant <= w_grantId;
                        r_owner     <= w_grantId;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_arHandshake) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_rHandshake && M_RLAST) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign M_ARVALID = w_inAddr;
    assign M_ARADDR  = r_araddr;
    assign M_ARLEN   = r_arlen;
    assign M_ARID    = r_arid;
    assign M_RREADY  = w_inData & w_ownerRready;

    // The R channel reaches only the owner; the other port sees an idle, zeroed channel.
    assign w_selI = w_inData & (r_owner == REQ_IFETCH);
    assign w_selD = w_inData & (r_owner == REQ_LOAD);

    assign I_RVALID = w_selI & M_RVALID;
    assign I_RDATA  = w_selI ? M_RDATA : '0;
    assign I_RRESP  = w_selI ? M_RRESP : RESP_OKAY;
    assign I_RLAST  = w_selI & M_RLAST;

    assign D_RVALID = w_selD & M_RVALID;
    assign D_RDATA  = w_selD ? M_RDATA : '0;
    assign D_RRESP  = w_selD ? M_RRESP : RESP_OKAY;
    assign D_RLAST  = w_selD & M_RLAST;

    assign BUSY  = ~w_isIdle;
    assign OWNER = r_owner;

`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_stallCnt;
    logic        r_timeout;

    // Counts cycles without channel progress; the flag only reports, it never alters the FSM.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_stallCnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_isIdle || w_arHandshake || w_rHandshake) begin
            r_stallCnt <= '0;
        end else if (r_stallCnt != 16'hFFFF) begin
            r_stallCnt <= r_stallCnt + 16'd1;
            if (r_stallCnt + 16'd1 == TIMEOUT_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign TIMEOUT = r_timeout;
`else
    assign TIMEOUT = 1'b0;
`endif

    a_ridMatch : assert property (@(posedge ACLK) disable iff (ARESET)
        (w_inData && M_RVALID) |-> (M_RID == r_arid));

    a_arStable : assert property (@(posedge ACLK) disable iff (ARESET)
        (w_inAddr && !M_ARREADY) |=> ($stable(M_ARADDR) && $stable(M_ARLEN) && $stable(M_ARID)));

    a_grantOnehot : assert property (@(posedge ACLK) disable iff (ARESET)
        $onehot0(w_grant));

endmodule
